// File: rtl/sys_defs.sv
// Shared bus encodings, request sizes, tag space and owner identifiers
// for the memory-side arbiter and its tag table.
package sys_defs;

  localparam int NTAGS = 16;
  localparam int TAG_W = $clog2(NTAGS);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic {
    OWN_DMEM = 1'b0,
    OWN_IMEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_tag_table.sv
// Valid/owner record per outstanding memory tag; lookup is combinational,
// alloc/free land at the next edge with alloc winning a same-tag collision.
module mem_tag_table
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_t           alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output owner_t           lookup_owner,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag
);

  logic [NTAGS-1:0] valid;
  owner_t           owner [NTAGS];

  assign lookup_valid = valid[lookup_tag];
  assign lookup_owner = owner[lookup_tag];

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < NTAGS; i++) owner[i] <= OWN_DMEM;
    end else begin
      if (free_en) valid[free_tag] <= 1'b0;
      // Later assignment wins: a tag reissued in its own return cycle stays live.
      if (alloc_en) begin
        valid[alloc_tag] <= 1'b1;
        owner[alloc_tag] <= alloc_owner;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges Dmem and Imem requests onto proc2mem and steers tagged returns back;
// zero-cycle request/return paths, the loser simply sees response 0 and retries.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        Dmem_command,
  input  logic [ADDR_W-1:0] Dmem_addr,
  input  logic [1:0]        Dmem_size,
  input  logic [63:0]       Dmem_data,
  output logic [TAG_W-1:0]  dmem_response,
  output logic [63:0]       dmem_data,
  output logic [TAG_W-1:0]  dmem_tag,
  input  logic [1:0]        Imem_command,
  input  logic [ADDR_W-1:0] Imem_addr,
  output logic [TAG_W-1:0]  imem_response,
  output logic [63:0]       imem_data,
  output logic [TAG_W-1:0]  imem_tag,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [1:0]        proc2mem_size,
  output logic [63:0]       proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic [7:0]        orphan_cnt
);

  logic [2:0]       starve_cnt;
  logic             dmem_req, imem_req, imem_forced;
  logic             dmem_win, imem_win;
  logic [TAG_W-1:0] accept_tag;
  logic             alloc_en, lookup_valid, ret_hit, ret_orphan;
  owner_t           lookup_owner;

  assign dmem_req    = (Dmem_command != BUS_NONE);
  assign imem_req    = (Imem_command != BUS_NONE);
  // Dmem only yields to a starved Imem that is actually asking this cycle.
  assign imem_forced = imem_req && (starve_cnt >= 3'(STARVE_MAX));
  assign dmem_win    = dmem_req && !imem_forced;
  assign imem_win    = imem_req && !dmem_win;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_size    = '0;
    proc2mem_data    = '0;
    if (dmem_win) begin
      proc2mem_command = Dmem_command;
      proc2mem_addr    = Dmem_addr;
      proc2mem_size    = Dmem_size;
      proc2mem_data    = Dmem_data;
    end else if (imem_win) begin
      proc2mem_command = Imem_command;
      proc2mem_addr    = Imem_addr;
      proc2mem_size    = DOUBLE;
    end
    if (!reset) proc2mem_command = BUS_NONE;
  end

  assign accept_tag    = reset ? mem2proc_response : '0;
  assign dmem_response = dmem_win ? accept_tag : '0;
  assign imem_response = imem_win ? accept_tag : '0;

  // Stores get no return tag, so only loads are recorded.
  assign alloc_en = (accept_tag != '0) &&
                    ((dmem_win && Dmem_command == BUS_LOAD) ||
                     (imem_win && Imem_command == BUS_LOAD));

  assign ret_hit    = reset && (mem2proc_tag != '0) && lookup_valid;
  assign ret_orphan = reset && (mem2proc_tag != '0) && !lookup_valid;

  assign dmem_data = mem2proc_data;
  assign imem_data = mem2proc_data;
  assign dmem_tag  = (ret_hit && lookup_owner == OWN_DMEM) ? mem2proc_tag : '0;
  assign imem_tag  = (ret_hit && lookup_owner == OWN_IMEM) ? mem2proc_tag : '0;

  mem_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (alloc_en),
    .alloc_tag    (accept_tag),
    .alloc_owner  (imem_win ? OWN_IMEM : OWN_DMEM),
    .lookup_tag   (mem2proc_tag),
    .lookup_valid (lookup_valid),
    .lookup_owner (lookup_owner),
    .free_en      (ret_hit),
    .free_tag     (mem2proc_tag)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
      orphan_cnt <= '0;
    end else begin
      if (!imem_req || (imem_win && mem2proc_response != '0))
        starve_cnt <= '0;
      else if (starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;
      if (ret_orphan && orphan_cnt != 8'hFF)
        orphan_cnt <= orphan_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a tag-ownership reference model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Dmem_command, Dmem_size, Imem_command;
  logic [15:0] Dmem_addr, Imem_addr;
  logic [63:0] Dmem_data;
  logic [3:0]  dmem_response, dmem_tag, imem_response, imem_tag;
  logic [63:0] dmem_data, imem_data;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [7:0]  orphan_cnt;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_size(Dmem_size),
    .Dmem_data(Dmem_data), .dmem_response(dmem_response), .dmem_data(dmem_data),
    .dmem_tag(dmem_tag), .Imem_command(Imem_command), .Imem_addr(Imem_addr),
    .imem_response(imem_response), .imem_data(imem_data), .imem_tag(imem_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag), .orphan_cnt(orphan_cnt)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: which side owns each live tag, how long Imem has been denied.
  bit m_live [16];
  bit m_is_imem [16];
  int m_denied;
  int m_orphans;
  bit e_run, e_dwin, e_iwin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] dc, input logic [15:0] da, input logic [1:0] ic,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    Dmem_command = dc; Dmem_addr = da; Dmem_size = 2'd2; Dmem_data = {48'h0, da};
    Imem_command = ic; Imem_addr = da ^ 16'h8000;
    mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
  endtask

  task automatic sample();
    bit dreq, ireq, hit;
    logic [3:0] t, e_dtag, e_itag;
    #1;
    e_run = (reset === 1'b1);
    dreq = (Dmem_command != 2'd0);
    ireq = (Imem_command != 2'd0);
    e_dwin = dreq && !(ireq && m_denied >= 4);
    e_iwin = ireq && !e_dwin;
    check("p2m_cmd", proc2mem_command,
          !e_run ? 2'd0 : e_dwin ? Dmem_command : e_iwin ? Imem_command : 2'd0);
    check("p2m_addr", proc2mem_addr, e_dwin ? Dmem_addr : e_iwin ? Imem_addr : 16'h0);
    check("p2m_size", proc2mem_size, e_dwin ? Dmem_size : e_iwin ? 2'd3 : 2'd0);
    check("p2m_data", proc2mem_data, e_dwin ? Dmem_data : 64'h0);
    check("dmem_resp", dmem_response, (e_run && e_dwin) ? mem2proc_response : 4'd0);
    check("imem_resp", imem_response, (e_run && e_iwin) ? mem2proc_response : 4'd0);
    t = mem2proc_tag;
    hit = e_run && t != 0 && m_live[t];
    e_dtag = (hit && !m_is_imem[t]) ? t : 4'd0;
    e_itag = (hit && m_is_imem[t]) ? t : 4'd0;
    check("dmem_tag", dmem_tag, e_dtag);
    check("imem_tag", imem_tag, e_itag);
    check("dmem_data", dmem_data, mem2proc_data);
    check("imem_data", imem_data, mem2proc_data);
    check("orphan_cnt", orphan_cnt, m_orphans);
  endtask

  task automatic adv();
    logic [3:0] t, r;
    @(posedge clock);
    t = mem2proc_tag;
    r = mem2proc_response;
    if (!e_run) begin
      foreach (m_live[i]) m_live[i] = 0;
      m_denied = 0;
      m_orphans = 0;
    end else begin
      if (t != 0) begin
        if (m_live[t]) m_live[t] = 0;
        else if (m_orphans < 255) m_orphans++;
      end
      if (r != 0 && ((e_dwin && Dmem_command == 2'd1) || (e_iwin && Imem_command == 2'd1))) begin
        m_live[r] = 1;
        m_is_imem[r] = e_iwin;
      end
      if (Imem_command == 2'd0 || (e_iwin && r != 0)) m_denied = 0;
      else if (m_denied < 7) m_denied++;
    end
    @(negedge clock);
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    int live_list [$];
    int pick;
    foreach (m_live[i]) begin m_live[i] = 0; m_is_imem[i] = 0; end
    m_denied = 0;
    m_orphans = 0;
    reset = 1'b0;
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0);
    repeat (2) @(negedge clock);
    drive(2'd1, 16'h0040, 2'd1, 4'd5, 4'd0, 64'h0);
    cyc();
    check("rst_dresp", dmem_response, 4'd0);
    reset = 1'b1;

    // Single Dmem load, tag 3 returning two cycles later.
    drive(2'd1, 16'h0100, 2'd0, 4'd3, 4'd0, 64'h0);
    sample(); check("t1_dresp", dmem_response, 4'd3); adv();
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0); cyc();
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd3, 64'hDEAD);
    sample();
    check("t1_dtag", dmem_tag, 4'd3);
    check("t1_ddata", dmem_data, 64'hDEAD);
    check("t1_itag", imem_tag, 4'd0);
    adv();

    // Contention: four Dmem wins, then Imem forced, then Dmem again.
    for (int i = 1; i <= 5; i++) begin
      drive(2'd1, 16'h0200 + 16'(i), 2'd1, 4'(i), 4'd0, 64'h0);
      sample();
      check("t2_dresp", dmem_response, (i < 5) ? 4'(i) : 4'd0);
      check("t2_iresp", imem_response, (i < 5) ? 4'd0 : 4'(i));
      adv();
    end
    drive(2'd1, 16'h0300, 2'd1, 4'd6, 4'd0, 64'h0);
    sample(); check("t2_after", dmem_response, 4'd6); adv();

    // Store accept is not recorded; its tag coming back is an orphan.
    drive(2'd2, 16'h0400, 2'd0, 4'd7, 4'd0, 64'h0); cyc();
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd7, 64'h1234);
    sample(); check("t3_dtag", dmem_tag, 4'd0); check("t3_itag", imem_tag, 4'd0); adv();
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0);
    sample(); check("t3_orphan", orphan_cnt, 8'd1); adv();

    // Same-cycle return to Imem and reallocation of tag 2 to Dmem.
    drive(2'd0, 16'h0500, 2'd1, 4'd2, 4'd0, 64'h0); cyc();
    drive(2'd1, 16'h0504, 2'd0, 4'd2, 4'd2, 64'hAAAA);
    sample(); check("t4_itag", imem_tag, 4'd2); check("t4_dtag", dmem_tag, 4'd0); adv();
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd2, 64'hBBBB);
    sample(); check("t4_dtag2", dmem_tag, 4'd2); check("t4_itag2", imem_tag, 4'd0); adv();

    // Loads in flight across a reset pulse come back as orphans.
    for (int i = 8; i <= 10; i++) begin
      drive(2'd1, 16'h0600 + 16'(i), 2'd0, 4'(i), 4'd0, 64'h0); cyc();
    end
    reset = 1'b0;
    drive(2'd1, 16'h0700, 2'd1, 4'd11, 4'd0, 64'h0);
    sample(); check("t5_rcmd", proc2mem_command, 2'd0); check("t5_riresp", imem_response, 4'd0); adv();
    reset = 1'b1;
    for (int i = 8; i <= 10; i++) begin
      drive(2'd0, 16'h0, 2'd0, 4'd0, 4'(i), 64'h55);
      sample(); check("t5_dtag", dmem_tag, 4'd0); check("t5_itag", imem_tag, 4'd0); adv();
    end
    drive(2'd0, 16'h0, 2'd0, 4'd0, 4'd0, 64'h0);
    sample(); check("t5_orphan", orphan_cnt, 8'd3); adv();

    // Memory rejecting everything: no grants stick, Imem denial accumulates.
    for (int i = 0; i < 4; i++) begin
      drive(2'd1, 16'h0800, 2'd1, 4'd0, 4'd0, 64'h0);
      sample(); check("t6_dresp", dmem_response, 4'd0); check("t6_iresp", imem_response, 4'd0); adv();
    end
    drive(2'd1, 16'h0804, 2'd1, 4'd12, 4'd0, 64'h0);
    sample(); check("t6_forced", imem_response, 4'd12); adv();

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      live_list.delete();
      foreach (m_live[i]) if (m_live[i]) live_list.push_back(i);
      pick = $urandom_range(0, 3);
      reset = ($urandom_range(0, 39) != 0);
      Dmem_command = 2'($urandom_range(0, 2));
      Imem_command = 2'($urandom_range(0, 1));
      Dmem_addr = 16'($urandom); Imem_addr = 16'($urandom);
      Dmem_size = 2'($urandom_range(0, 3));
      Dmem_data = {$urandom, $urandom};
      mem2proc_data = {$urandom, $urandom};
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (pick == 0) mem2proc_tag = 4'd0;
      else if (pick == 1 || live_list.size() == 0) mem2proc_tag = 4'($urandom_range(0, 15));
      else mem2proc_tag = 4'(live_list[$urandom_range(0, live_list.size() - 1)]);
      if ($urandom_range(0, 7) == 0) mem2proc_response = mem2proc_tag;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
